xgxs_enc_8b10b_lanes: RTL and testbench
=======================================

Name: xgxs_enc_8b10b_lanes

Overview:
Parametrised multi-lane 8b/10b encoder for the XGXS transmit path. It replaces the single-byte encoder. It encodes LANES bytes per accepted word, chaining running disparity lane 0 -> lane LANES-1 within the word and across words. It adds a valid/ready handshake, illegal-K detection with a saturating error counter, and a disparity-inversion test hook.

Parameters:
LANES, 4, number of byte lanes per word (1..8)
INIT_RD, 0, running disparity after reset (0 = RD-, 1 = RD+)
CNT_W, 16, width of the illegal-K error counter

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  encoder can accept a word this cycle
in_data  in  8*LANES  lane i byte in bits [8i+7:8i], HGF EDCBA order
in_k  in  LANES  lane i is a control (K) character
inj_disp  in  1  when set on an accepted word, inverts the RD fed to lane 0 (fault injection)
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts encoded word
out_data  out  10*LANES  lane i code in bits [10i+9:10i]: bit0..5 = a b c d e i, bit6..9 = f g h j
out_disp  out  1  running disparity after the last lane of the word on out_data (1 = RD+)
err_k  out  LANES  lane i of the word on out_data was an illegal K request
err_cnt  out  CNT_W  count of illegal-K lanes since reset; saturates at all-ones

Behaviour:
- Accept: in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational). Single output register stage.
- Latency: a word accepted in cycle N appears on out_data in cycle N+1. Full throughput when out_ready stays high.
- Hold: out_data, out_disp and err_k are held stable while out_valid & ~out_ready.
- out_valid rules: set on accept. Cleared when out_ready is high and nothing is accepted that cycle.
- RD chain on accept:
  - rd0 = rd_q ^ inj_disp.
  - Lane i encodes with rd_i per IEEE 802.3 Clause 36: 5b/6b then 3b/4b, with sub-block disparity applied between them.
  - rd_{i+1} is the RD after lane i.
  - rd_q and out_disp are loaded with rd_LANES.
- Alternate codes: D.x.A7 alternate is used for x=17,18,20 at RD- and x=11,13,14 at RD+.
- Legal K set: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
- Illegal K: in_k set with any other byte.
  - The lane is encoded as the D character of the same byte, and its err_k bit is set.
  - RD follows the emitted D code.
  - err_cnt adds popcount of the illegal lanes on accept, saturating at 2^CNT_W-1. No wrap.
- rd_q changes only on accept. Stalls never alter disparity.
- Reset values (synchronous, takes priority over every other event including a simultaneous accept):
  - out_valid=0, out_data=0, err_k=0, err_cnt=0.
  - rd_q=INIT_RD, out_disp=INIT_RD.
  - A word in flight at reset is dropped. in_ready=1 the cycle after reset.
- No state machine beyond the valid register and rd_q. All encoding is combinational from in_* into the output register.

Test Plan:
- Single word: LANES=1, INIT_RD=0, in_data=8'h00, in_k=0 -> next cycle out_data=10'h0B9, out_disp=0, err_k=0.
- RD chaining: LANES=4, all lanes 8'hBC with in_k=4'hF after reset -> out_data lanes 0..3 = 10'h17C, 10'h283, 10'h17C, 10'h283; out_disp=0. A second identical word repeats the same codes.
- Injection: LANES=1, K28.5 with inj_disp=1 from RD- -> out_data=10'h283, out_disp=0. A following K28.5 without injection -> 10'h17C.
- Backpressure: stream 8 words with out_ready toggling 1,0,0,1 -> no word lost or duplicated. out_data is stable while stalled. in_ready=0 exactly when out_valid=1 and out_ready=0. RD sequence matches the reference model.
- Illegal K: LANES=4, lane 2 = 8'h00 with in_k=1, others legal -> err_k=4'b0100, lane 2 code = D0.0 for its RD, err_cnt=1. With CNT_W=2 and 5 such words -> err_cnt holds at 3.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_disp=INIT_RD, err_cnt=0. The first word after reset is encoded from INIT_RD.

Source files
------------

// File: rtl/xgxs_enc_8b10b_lanes_if.sv
// Handshake and data bundle for the multi-lane 8b/10b encoder.
// The slave side is the encoder. The master side is whatever feeds it and drains it.
interface xgxs_enc_8b10b_lanes_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*LANES-1:0]    in_data;
    logic [LANES-1:0]      in_k;
    logic                  inj_disp;
    logic                  out_valid;
    logic                  out_ready;
    logic [10*LANES-1:0]   out_data;
    logic                  out_disp;
    logic [LANES-1:0]      err_k;
    logic [CNT_W-1:0]      err_cnt;

    modport slave (
        input  in_valid, in_data, in_k, inj_disp, out_ready,
        output in_ready, out_valid, out_data, out_disp, err_k, err_cnt
    );

    modport master (
        output in_valid, in_data, in_k, inj_disp, out_ready,
        input  in_ready, out_valid, out_data, out_disp, err_k, err_cnt
    );
endinterface

// File: rtl/xgxs_enc_8b10b_lanes.sv
// Multi-lane 8b/10b encoder for the XGXS transmit path.
// Running disparity chains from lane 0 to the top lane of each word and then carries into the next word.
module xgxs_enc_8b10b_lanes #(
    parameter int LANES   = 4,
    parameter bit INIT_RD = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    xgxs_enc_8b10b_lanes_if.slave bus
);
    localparam int CW4 = CNT_W + 4;

    typedef struct packed {
        logic [9:0] code;
        logic       rd;
        logic       bad;
    } lane_t;

    // The 6b and 4b tables are written with a/f as the MSB, in RD- form, and bit-reversed on output.
    function automatic lane_t enc_lane(input logic [7:0] d, input logic k, input logic rd);
        lane_t      r;
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] t6;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       legal;
        logic       kk;
        logic       rd6;
        logic       alt;
        r     = '0;
        x     = d[4:0];
        y     = d[7:5];
        legal = (x == 5'd28) ||
                ((y == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
        kk    = k & legal;
        r.bad = k & ~legal;
        t6    = '0;
        case (x)
            5'd0:  t6 = 6'b100111;  5'd1:  t6 = 6'b011101;
            5'd2:  t6 = 6'b101101;  5'd3:  t6 = 6'b110001;
            5'd4:  t6 = 6'b110101;  5'd5:  t6 = 6'b101001;
            5'd6:  t6 = 6'b011001;  5'd7:  t6 = 6'b111000;
            5'd8:  t6 = 6'b111001;  5'd9:  t6 = 6'b100101;
            5'd10: t6 = 6'b010101;  5'd11: t6 = 6'b110100;
            5'd12: t6 = 6'b001101;  5'd13: t6 = 6'b101100;
            5'd14: t6 = 6'b011100;  5'd15: t6 = 6'b010111;
            5'd16: t6 = 6'b011011;  5'd17: t6 = 6'b100011;
            5'd18: t6 = 6'b010011;  5'd19: t6 = 6'b110010;
            5'd20: t6 = 6'b001011;  5'd21: t6 = 6'b101010;
            5'd22: t6 = 6'b011010;  5'd23: t6 = 6'b111010;
            5'd24: t6 = 6'b110011;  5'd25: t6 = 6'b100110;
            5'd26: t6 = 6'b010110;  5'd27: t6 = 6'b110110;
            5'd28: t6 = 6'b001110;  5'd29: t6 = 6'b101110;
            5'd30: t6 = 6'b011110;  5'd31: t6 = 6'b101011;
            default: t6 = '0;
        endcase
        if (kk && x == 5'd28) begin
            c6  = rd ? 6'b110000 : 6'b001111;
            rd6 = ~rd;
        end else if ($countones(t6) != 3) begin
            c6  = rd ? ~t6 : t6;
            rd6 = ~rd;
        end else if (x == 5'd7) begin
            c6  = rd ? 6'b000111 : 6'b111000;
            rd6 = rd;
        end else begin
            c6  = t6;
            rd6 = rd;
        end
        alt = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                  : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        case (y)
            3'd0:    c4 = rd6 ? 4'b0100 : 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = rd6 ? 4'b0011 : 4'b1100;
            3'd4:    c4 = rd6 ? 4'b0010 : 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = (kk || alt) ? (rd6 ? 4'b1000 : 4'b0111)
                                      : (rd6 ? 4'b0001 : 4'b1110);
        endcase
        // Balanced K28 trailers are the complement of the data trailer when entered at RD-.
        if (kk && !rd6 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
            c4 = ~c4;
        r.rd   = ($countones(c4) != 2) ? ~rd6 : rd6;
        r.code = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
        return r;
    endfunction

    logic                  valid_q;
    logic [10*LANES-1:0]   data_q;
    logic [LANES-1:0]      errk_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rd_q;

    logic                  accept;
    logic                  rd_c;
    lane_t                 lane_r;
    logic [10*LANES-1:0]   enc_data;
    logic [LANES-1:0]      enc_bad;
    logic [3:0]            n_bad;
    logic [CW4-1:0]        cnt_sum;
    logic [CNT_W-1:0]      cnt_next;

    assign bus.in_ready  = ~valid_q | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_disp  = rd_q;
    assign bus.err_k     = errk_q;
    assign bus.err_cnt   = cnt_q;

    always_comb begin
        rd_c     = rd_q ^ bus.inj_disp;
        lane_r   = '0;
        enc_data = '0;
        enc_bad  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_r               = enc_lane(bus.in_data[8*i +: 8], bus.in_k[i], rd_c);
            enc_data[10*i +: 10] = lane_r.code;
            enc_bad[i]           = lane_r.bad;
            rd_c                 = lane_r.rd;
        end
    end

    always_comb begin
        n_bad = '0;
        for (int unsigned i = 0; i < LANES; i++)
            n_bad = n_bad + {3'b000, enc_bad[i]};
        cnt_sum  = CW4'(cnt_q) + CW4'(n_bad);
        cnt_next = (|cnt_sum[CW4-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            errk_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= INIT_RD;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= enc_data;
            errk_q  <= enc_bad;
            cnt_q   <= cnt_next;
            rd_q    <= rd_c;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xgxs_enc_8b10b_lanes.sv
// Directed bench for the multi-lane 8b/10b encoder: one single-lane and one four-lane instance.
module tb_xgxs_enc_8b10b_lanes;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    xgxs_enc_8b10b_lanes_if #(.LANES(1), .CNT_W(16)) b1 ();
    xgxs_enc_8b10b_lanes_if #(.LANES(4), .CNT_W(2))  b4 ();

    xgxs_enc_8b10b_lanes #(.LANES(1), .INIT_RD(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );
    xgxs_enc_8b10b_lanes #(.LANES(4), .INIT_RD(1'b0), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_k = '0; b1.inj_disp = 1'b0; b1.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_k = '0; b4.inj_disp = 1'b0; b4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] bp_d  [8] = '{8'h00, 8'hBC, 8'hB5, 8'h03, 8'hE7, 8'hF1, 8'hF1, 8'h1C};
    logic       bp_k  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0] bp_c  [8] = '{10'h0B9, 10'h17C, 10'h155, 10'h0A3, 10'h1C7, 10'h231, 10'h3B1, 10'h343};
    logic       bp_rd [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    logic [3:0] pat;
    logic       ev;
    logic       ordy;
    int         idx;
    int         got;

    initial begin
        total = 0;
        bad   = 0;
        do_reset();

        check("rst_valid", b1.out_valid, 1'b0);
        check("rst_data",  b1.out_data, 10'h000);
        check("rst_disp",  b1.out_disp, 1'b0);
        check("rst_cnt",   b4.err_cnt, 2'd0);
        check("rst_ready", b1.in_ready, 1'b1);

        // single D0.0 on the one-lane encoder
        b1.in_valid = 1'b1; b1.in_data = 8'h00; b1.in_k = 1'b0;
        @(posedge clk); @(negedge clk);
        b1.in_valid = 1'b0;
        check("single_valid", b1.out_valid, 1'b1);
        check("single_data",  b1.out_data, 10'h0B9);
        check("single_disp",  b1.out_disp, 1'b0);
        check("single_errk",  b1.err_k, 1'b0);

        // four K28.5 lanes, two words back to back
        b4.in_valid = 1'b1; b4.in_data = 32'hBCBCBCBC; b4.in_k = 4'hF;
        @(posedge clk); @(negedge clk);
        check("chain1_data", b4.out_data, {10'h283, 10'h17C, 10'h283, 10'h17C});
        check("chain1_disp", b4.out_disp, 1'b0);
        check("chain1_errk", b4.err_k, 4'h0);
        @(posedge clk); @(negedge clk);
        b4.in_valid = 1'b0;
        check("chain2_data", b4.out_data, {10'h283, 10'h17C, 10'h283, 10'h17C});
        check("chain2_disp", b4.out_disp, 1'b0);

        // disparity injection on the one-lane encoder (currently RD-)
        b1.in_valid = 1'b1; b1.in_data = 8'hBC; b1.in_k = 1'b1; b1.inj_disp = 1'b1;
        @(posedge clk); @(negedge clk);
        b1.inj_disp = 1'b0;
        check("inj_data", b1.out_data, 10'h283);
        check("inj_disp", b1.out_disp, 1'b0);
        @(posedge clk); @(negedge clk);
        b1.in_valid = 1'b0;
        check("post_inj_data", b1.out_data, 10'h17C);
        check("post_inj_disp", b1.out_disp, 1'b1);

        // illegal K on lane 2, counter width 2 saturates
        b4.in_valid = 1'b1; b4.in_data = 32'hBC00BCBC; b4.in_k = 4'hF;
        @(posedge clk); @(negedge clk);
        check("ill1_data", b4.out_data, {10'h17C, 10'h0B9, 10'h283, 10'h17C});
        check("ill1_errk", b4.err_k, 4'b0100);
        check("ill1_cnt",  b4.err_cnt, 2'd1);
        check("ill1_disp", b4.out_disp, 1'b1);
        @(posedge clk); @(negedge clk);
        check("ill2_data", b4.out_data, {10'h283, 10'h346, 10'h17C, 10'h283});
        check("ill2_cnt",  b4.err_cnt, 2'd2);
        check("ill2_disp", b4.out_disp, 1'b0);
        @(posedge clk); @(negedge clk);
        check("ill3_cnt", b4.err_cnt, 2'd3);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        b4.in_valid = 1'b0;
        check("ill5_cnt",  b4.err_cnt, 2'd3);
        check("ill5_errk", b4.err_k, 4'b0100);

        // backpressure stream on the one-lane encoder, out_ready cycling 1,0,0,1
        do_reset();
        pat = 4'b1001;
        ev  = 1'b0;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            ordy         = pat[cyc % 4];
            b1.out_ready = ordy;
            b1.in_valid  = (idx < 8);
            b1.in_data   = bp_d[(idx < 8) ? idx : 7];
            b1.in_k      = bp_k[(idx < 8) ? idx : 7];
            #1;
            check("bp_valid", b1.out_valid, ev);
            check("bp_ready", b1.in_ready, !ev || ordy);
            if (ev && !ordy)
                check("bp_hold", b1.out_data, bp_c[got]);
            if (ev && ordy) begin
                check("bp_data", b1.out_data, bp_c[got]);
                check("bp_disp", b1.out_disp, bp_rd[got]);
                got++;
            end
            if ((idx < 8) && (!ev || ordy)) begin
                idx++;
                ev = 1'b1;
            end else if (ordy) begin
                ev = 1'b0;
            end
        end
        b1.in_valid = 1'b0;
        check("bp_count", got, 8);

        // reset while a word is stalled on the four-lane encoder
        @(negedge clk);
        b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_data = 32'hBC00BCBC; b4.in_k = 4'hF;
        @(posedge clk); @(negedge clk);
        check("mid_valid", b4.out_valid, 1'b1);
        check("mid_ready", b4.in_ready, 1'b0);
        check("mid_cnt",   b4.err_cnt, 2'd1);
        check("mid_disp",  b4.out_disp, 1'b1);
        rst = 1'b1;
        b4.in_data = 32'hBCBCBCBC;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst2_valid", b4.out_valid, 1'b0);
        check("rst2_disp",  b4.out_disp, 1'b0);
        check("rst2_cnt",   b4.err_cnt, 2'd0);
        check("rst2_ready", b4.in_ready, 1'b1);
        b4.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        b4.in_valid = 1'b0;
        check("rst2_data", b4.out_data, {10'h283, 10'h17C, 10'h283, 10'h17C});
        check("rst2_d_disp", b4.out_disp, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
